// File: rtl/fpadd_pkg.sv
// Shared FP16 field definitions, flag layout and result classifier for the
// FP16 adder output buffer.
package fpadd_pkg;

    localparam int unsigned EXP_W   = 5;
    localparam int unsigned MAN_W   = 10;
    localparam int unsigned FP_W    = 1 + EXP_W + MAN_W;
    localparam int unsigned FLG_W   = 4;
    localparam int unsigned ENTRY_W = FLG_W + FP_W;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

    // Bit positions inside a packed flag nibble {nan, inf, zero, sign}
    localparam int unsigned FLG_NAN  = 3;
    localparam int unsigned FLG_INF  = 2;
    localparam int unsigned FLG_ZERO = 1;
    localparam int unsigned FLG_SIGN = 0;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic sign;
    } fp16_flags_t;

    // Subnormals deliberately map to no flag at all.
    function automatic fp16_flags_t fp16_classify(input logic [FP_W-1:0] v);
        fp16_flags_t        f;
        logic [EXP_W-1:0]   e;
        logic [MAN_W-1:0]   m;
        e      = v[FP_W-2:MAN_W];
        m      = v[MAN_W-1:0];
        f.nan  = (e == EXP_MAX) && (m != '0);
        f.inf  = (e == EXP_MAX) && (m == '0);
        f.zero = (e == '0) && (m == '0);
        f.sign = v[FP_W-1];
        return f;
    endfunction

endpackage

// File: rtl/fpadd_obuf_fifo.sv
// Show-ahead FIFO holding classified adder results. The writer only asserts
// wr_en_i for accepted pushes, so count never leaves [0, DEPTH].
module fpadd_obuf_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 20
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy next-state; pointers wrap naturally at 2**AW
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head entry, forced to zero while empty so reset shows a clean output
    always_comb begin
        rd_data_o = '0;
        if (count_q != '0) begin
            rd_data_o = mem_q[rd_ptr_q];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fpadd_out_buffer.sv
// Result buffer behind the non-stalling 4-stage FP16 adder: tracks in-flight
// adds in a valid shadow pipeline, classifies each result, queues it, and
// grants issue credit so accepted results are never lost.
// Optional result/exception counters are built when FPADD_OBUF_STATS_EN is defined.
module fpadd_out_buffer
    import fpadd_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LAT   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     issue_valid_i,
    output logic                     issue_ok_o,
    input  logic [15:0]              res_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [15:0]              out_data_o,
    output logic [3:0]               out_flags_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
`ifdef FPADD_OBUF_STATS_EN
    ,
    output logic [15:0]              res_cnt_o,
    output logic [15:0]              exc_cnt_o
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
    localparam logic [CW:0]   DepthSum = (CW + 1)'(DEPTH);

    logic [LAT-1:0]     vld_sr_q, vld_sr_d;
    logic               overflow_q, overflow_d;
    logic [CW-1:0]      count;
    logic [CW:0]        inflight;
    logic               push, pop, push_acc;
    fp16_flags_t        res_flags;
    logic [ENTRY_W-1:0] head;

    assign push      = vld_sr_q[LAT-1];
    assign res_flags = fp16_classify(res_i);
    assign pop       = out_valid_o && out_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign push_acc  = push && ((count < DepthCnt) || pop);

    // Shadow valid pipeline and sticky overflow next-state
    always_comb begin
        vld_sr_d   = (vld_sr_q << 1) | LAT'(issue_valid_i);
        overflow_d = overflow_q;
        if (push && !push_acc) begin
            overflow_d = 1'b1;
        end
    end

    // Shadow pipeline and overflow registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_sr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            vld_sr_q   <= vld_sr_d;
            overflow_q <= overflow_d;
        end
    end

    // Credit: occupied plus in-flight must stay below DEPTH; registers only
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(LAT); i++) begin
            inflight = inflight + (CW + 1)'(vld_sr_q[i]);
        end
        issue_ok_o = ({1'b0, count} + inflight) < DepthSum;
    end

    fpadd_obuf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (push_acc),
        .wr_data_i ({res_flags, res_i}),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .count_o   (count)
    );

    assign out_valid_o = (count != '0);
    assign out_data_o  = head[FP_W-1:0];
    assign out_flags_o = head[ENTRY_W-1:FP_W];
    assign count_o     = count;
    assign overflow_o  = overflow_q;

`ifdef FPADD_OBUF_STATS_EN
    logic [15:0] res_cnt_q, res_cnt_d;
    logic [15:0] exc_cnt_q, exc_cnt_d;

    // Saturating counters of accepted pushes and of accepted NaN/Inf results
    always_comb begin
        res_cnt_d = res_cnt_q;
        exc_cnt_d = exc_cnt_q;
        if (push_acc && (res_cnt_q != 16'hFFFF)) begin
            res_cnt_d = res_cnt_q + 16'd1;
        end
        if (push_acc && (res_flags.nan || res_flags.inf) && (exc_cnt_q != 16'hFFFF)) begin
            exc_cnt_d = exc_cnt_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_cnt_q <= '0;
            exc_cnt_q <= '0;
        end else begin
            res_cnt_q <= res_cnt_d;
            exc_cnt_q <= exc_cnt_d;
        end
    end

    assign res_cnt_o = res_cnt_q;
    assign exc_cnt_o = exc_cnt_q;
`endif

endmodule
